tl45_fetch: RTL and testbench

TL45_FETCH -- requirements
Module: tl45_fetch

---
 rtl/tl45_fetch_if.sv | 21 ++
 rtl/tl45_fetch.sv | 148 ++++++++++++++
 tb/tb_tl45_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tl45_fetch_if.sv
// Wishbone pipelined-mode read port of the TL45 fetch stage.
// The master side is the fetch unit; the slave side is the instruction memory.
interface tl45_fetch_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic        i_wb_err;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_addr,
    input  i_wb_stall, i_wb_ack, i_wb_data, i_wb_err
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_addr,
    output i_wb_stall, i_wb_ack, i_wb_data, i_wb_err
  );
endinterface

// File: rtl/tl45_fetch.sv
// TL45 instruction fetch stage: one Wishbone read at a time, a one-entry
// skid register for words that arrive while decode is stalled, redirect
// handling with bus abort, and NOP bubbles when nothing is delivered.
// Optional macro TL45_FETCH_BUSERR_EN: a bus error parks the fetcher in an
// error state with a sticky o_fetch_err; otherwise an error reads as a NOP.
module tl45_fetch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  output logic        o_pipe_flush,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  tl45_fetch_if.master wb,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef TL45_FETCH_BUSERR_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  state_t      r_state;
  // In S_REQ, r_abort keeps cyc/stb low for one cycle after reset or after a
  // redirect that cut an active bus cycle short.
  logic        r_abort;
  logic [31:0] r_pc;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_inst;

  logic        w_cyc;
  logic        w_stb;
  logic        w_resp;
  logic [31:0] w_resp_data;
  logic [31:0] w_pc_next;

  assign w_cyc     = !r_abort && ((r_state == S_REQ) || (r_state == S_WAIT));
  assign w_stb     = !r_abort && (r_state == S_REQ);
  assign w_pc_next = r_pc + 32'd4;

`ifdef TL45_FETCH_BUSERR_EN
  logic r_fetch_err;
  // Errors are handled separately, so only a true ack completes a read.
  assign w_resp      = wb.i_wb_ack;
  assign w_resp_data = wb.i_wb_data;
  assign o_fetch_err = r_fetch_err;
`else
  // Without error tracking a bus error completes the read with a NOP word.
  assign w_resp      = wb.i_wb_ack | wb.i_wb_err;
  assign w_resp_data = wb.i_wb_err ? 32'd0 : wb.i_wb_data;
  assign o_fetch_err = 1'b0;
`endif

  assign wb.o_wb_cyc  = w_cyc;
  assign wb.o_wb_stb  = w_stb;
  assign wb.o_wb_addr = r_pc[31:2];
  assign o_pipe_flush = i_new_pc;
  assign o_buf_pc     = r_buf_pc;
  assign o_buf_inst   = r_buf_inst;

  // Bus FSM, PC, skid register and delivery buffer; reset > redirect > normal flow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_REQ;
      r_abort     <= 1'b1;
      r_pc        <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_inst <= 32'd0;
`ifdef TL45_FETCH_BUSERR_EN
      r_fetch_err <= 1'b0;
`endif
    end else if (i_new_pc) begin
      r_state     <= S_REQ;
      r_abort     <= w_cyc;
      r_pc        <= i_pc & 32'hFFFF_FFFC;
      r_buf_pc    <= 32'd0;
      r_buf_inst  <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_inst <= 32'd0;
`ifdef TL45_FETCH_BUSERR_EN
      r_fetch_err <= 1'b0;
`endif
    end else begin
      // Decode is consuming: emit a bubble unless a word is delivered below.
      if (!i_pipe_stall) begin
        r_buf_pc   <= 32'd0;
        r_buf_inst <= 32'd0;
      end
      case (r_state)
        S_REQ: begin
          if (r_abort) begin
            r_abort <= 1'b0;
          end else if (!wb.i_wb_stall) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef TL45_FETCH_BUSERR_EN
          if (wb.i_wb_err) begin
            r_state     <= S_ERR;
            r_fetch_err <= 1'b1;
          end else
`endif
          if (w_resp) begin
            if (!i_pipe_stall) begin
              r_buf_pc   <= r_pc;
              r_buf_inst <= w_resp_data;
              r_pc       <= w_pc_next;
              r_state    <= S_REQ;
            end else begin
              r_skid_pc   <= r_pc;
              r_skid_inst <= w_resp_data;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            r_buf_pc    <= r_skid_pc;
            r_buf_inst  <= r_skid_inst;
            r_skid_pc   <= 32'd0;
            r_skid_inst <= 32'd0;
            r_pc        <= w_pc_next;
            r_state     <= S_REQ;
          end
        end
`ifdef TL45_FETCH_BUSERR_EN
        S_ERR: begin
          r_state <= S_ERR;
        end
`endif
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl45_fetch.sv
// Testbench for tl45_fetch: directed vector table, then randomized traffic
// against a delivery-order scoreboard and a simple Wishbone slave model.
module tb_tl45_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pstall = 1'b0;
  logic        new_pc = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        flush;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        ferr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl45_fetch_if bus ();

  tl45_fetch dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pipe_stall (pstall),
    .i_new_pc     (new_pc),
    .i_pc         (pc_in),
    .o_pipe_flush (flush),
    .o_buf_pc     (buf_pc),
    .o_buf_inst   (buf_inst),
    .wb           (bus.master),
    .o_fetch_err  (ferr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r;
    logic        ps;
    logic        np;
    logic [31:0] pc;
    logic        ws;
    logic        ak;
    logic [31:0] d;
    logic        er;
    logic        cyc;
    logic        stb;
    logic [29:0] addr;
    logic [31:0] bpc;
    logic [31:0] binst;
    logic        fe;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ps, input logic np, input logic [31:0] pc,
                              input logic ws, input logic ak, input logic [31:0] d, input logic er,
                              input logic cyc, input logic stb, input logic [29:0] addr,
                              input logic [31:0] bpc, input logic [31:0] binst, input logic fe);
    vec_t v;
    v.r = r; v.ps = ps; v.np = np; v.pc = pc; v.ws = ws; v.ak = ak; v.d = d; v.er = er;
    v.cyc = cyc; v.stb = stb; v.addr = addr; v.bpc = bpc; v.binst = binst; v.fe = fe;
    return v;
  endfunction

  vec_t tv[$];

  // Reference model state for the random phase
  logic [31:0] exp_pc;
  logic [31:0] last_pc, last_inst;
  logic        prev_rst, prev_np, prev_ps, have_prev;
  logic [31:0] prev_target;
  logic        pend;
  logic [29:0] paddr;
  int          cnt;
  int          ndel;

  initial begin
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_data  = 32'd0;
    bus.i_wb_err   = 1'b0;

    //         r  ps np pc            ws ak data          er | cyc stb addr          bpc           binst         fe
    tv.push_back(mk(1, 1, 1, 32'h44,       0, 1, 32'h99,       0,  0, 0, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 1, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h08100001, 0,  1, 1, 30'h1,        32'h0,        32'h08100001, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h1,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h08100001, 0,  1, 1, 30'h2,        32'h4,        32'h08100001, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h2,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h08100001, 0,  1, 1, 30'h3,        32'h8,        32'h08100001, 0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0, 0, 0, 32'h0,      1, 0, 32'h0,        0,  1, 1, 30'h3,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h3,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'hAAAA0001, 0,  0, 0, 30'h3,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 30'h3,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 30'h3,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 1, 30'h4,        32'hC,        32'hAAAA0001, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h4,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 1, 1, 32'h103,      0, 1, 32'hDEADBEEF, 0,  0, 0, 30'h40,       32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h55,       0,  1, 1, 30'h40,       32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h40,       32'h0,        32'h0,        0));
`ifdef TL45_FETCH_BUSERR_EN
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h77,       1,  0, 0, 30'h40,       32'h0,        32'h0,        1));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 30'h40,       32'h0,        32'h0,        1));
    tv.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 0, 0, 32'h0,        0,  1, 1, 30'h3FFFFFFF, 32'h0,        32'h0,        0));
`else
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h77,       1,  1, 1, 30'h41,       32'h100,      32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h41,       32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 0, 0, 32'h0,        0,  0, 0, 30'h3FFFFFFF, 32'h0,        32'h0,        0));
`endif
    tv.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0,  1, 1, 30'h3FFFFFFF, 32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h3FFFFFFF, 32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h12345678, 0,  1, 1, 30'h0,        32'hFFFFFFFC, 32'h12345678, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 0, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h66,       0,  0, 0, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h67,       0,  1, 1, 30'h0,        32'h0,        32'h0,        0));
    tv.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h68,       0,  1, 1, 30'h0,        32'h0,        32'h0,        0));

    // Directed vectors: drive on the falling edge, check after the rising edge.
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].r; pstall = tv[i].ps; new_pc = tv[i].np; pc_in = tv[i].pc;
      bus.i_wb_stall = tv[i].ws; bus.i_wb_ack = tv[i].ak;
      bus.i_wb_data = tv[i].d; bus.i_wb_err = tv[i].er;
      #1;
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, tv[i].np});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cyc", i),   {31'd0, bus.o_wb_cyc}, {31'd0, tv[i].cyc});
      chk($sformatf("v%0d_stb", i),   {31'd0, bus.o_wb_stb}, {31'd0, tv[i].stb});
      chk($sformatf("v%0d_addr", i),  {2'd0, bus.o_wb_addr}, {2'd0, tv[i].addr});
      chk($sformatf("v%0d_bpc", i),   buf_pc, tv[i].bpc);
      chk($sformatf("v%0d_binst", i), buf_inst, tv[i].binst);
      chk($sformatf("v%0d_ferr", i),  {31'd0, ferr}, {31'd0, tv[i].fe});
    end

    // Random phase. Slave returns ~(byte address) so every real word is
    // nonzero and identifies its own address.
    exp_pc = 32'd0; last_pc = 32'd0; last_inst = 32'd0;
    prev_rst = 1'b0; prev_np = 1'b0; prev_ps = 1'b0; have_prev = 1'b0;
    prev_target = 32'd0; pend = 1'b0; paddr = 30'd0; cnt = 0; ndel = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (have_prev) begin
        if (prev_rst || prev_np) begin
          exp_pc = prev_rst ? 32'd0 : {prev_target[31:2], 2'b00};
          chk("rnd_flush_bpc", buf_pc, 32'd0);
          chk("rnd_flush_binst", buf_inst, 32'd0);
        end else if (prev_ps) begin
          chk("rnd_hold_bpc", buf_pc, last_pc);
          chk("rnd_hold_binst", buf_inst, last_inst);
        end else if (buf_inst != 32'd0) begin
          chk("rnd_dlv_pc", buf_pc, exp_pc);
          chk("rnd_dlv_inst", buf_inst, ~exp_pc);
          exp_pc = exp_pc + 32'd4;
          ndel++;
        end else begin
          chk("rnd_bubble_pc", buf_pc, 32'd0);
        end
        if (bus.o_wb_stb)
          chk("rnd_addr", {2'd0, bus.o_wb_addr}, {2'd0, exp_pc[31:2]});
        chk("rnd_stb_wo_cyc", {31'd0, bus.o_wb_stb & ~bus.o_wb_cyc}, 32'd0);
        chk("rnd_ferr", {31'd0, ferr}, 32'd0);
      end
      last_pc = buf_pc;
      last_inst = buf_inst;

      rst    = (i == 0) || ($urandom_range(0, 199) == 0);
      new_pc = !rst && ($urandom_range(0, 39) == 0);
      pc_in  = $urandom;
      pstall = ($urandom_range(0, 3) == 0);
      bus.i_wb_stall = ($urandom_range(0, 2) == 0);
      bus.i_wb_err   = 1'b0;
      bus.i_wb_ack   = 1'b0;
      bus.i_wb_data  = $urandom;
      if (!bus.o_wb_cyc) pend = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          bus.i_wb_ack  = 1'b1;
          bus.i_wb_data = ~{paddr, 2'b00};
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (($urandom_range(0, 7) == 0) && (!bus.o_wb_cyc || bus.o_wb_stb)) begin
        bus.i_wb_ack = 1'b1;
      end
      if (bus.o_wb_stb && !bus.i_wb_stall && !new_pc && !rst) begin
        pend  = 1'b1;
        paddr = bus.o_wb_addr;
        cnt   = $urandom_range(0, 2);
      end
      #1;
      chk("rnd_flush", {31'd0, flush}, {31'd0, new_pc});
      prev_rst = rst; prev_np = new_pc; prev_ps = pstall; prev_target = pc_in;
      have_prev = 1'b1;
    end
    chk("rnd_progress", {31'd0, (ndel > 100)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
